ex1_stage: RTL
==============

Name: ex1_stage

Overview:
- Operand-issue stage that produces the ALU inputs consumed by the EX2 ALU stage.
- Captures decoded instructions from ID and selects register or immediate operands.
- Resolves RAW hazards by forwarding from the EX2 result and the WB write port, and by inserting a one-cycle bubble on load-use.
- Registers `alu_in1`, `alu_in2` and `alu_op` so EX2 reads them directly from flops.

Parameters:
- DW, 16, datapath width.
- RW, 3, register-index width (8 registers; r0 hardwired to zero).
- CW, 8, bubble-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- id_valid  in  1  ID presents a valid instruction.
- id_alu_op  in  4  ALU operation code (ALU_ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5).
- id_rs1, id_rs2  in  RW  source register indices.
- id_rs1_val, id_rs2_val  in  DW  register-file read data.
- id_imm  in  DW  sign-extended immediate.
- id_use_imm  in  1  1 selects id_imm for operand 2; rs2 is then unused.
- id_rd  in  RW  destination index.
- id_reg_write  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load; its rd data arrives via the WB port.
- stall  in  1  downstream stall: hold all state.
- flush  in  1  branch/redirect: kill the instruction being captured.
- ex2_result  in  DW  combinational ALU result of the instruction currently held in this stage.
- wb_rd  in  RW  writeback destination index.
- wb_reg_write  in  1  writeback write enable.
- wb_data  in  DW  writeback data.
- alu_in1, alu_in2  out  DW  registered ALU operands.
- alu_op  out  4  registered ALU operation code.
- ex_valid  out  1  held instruction is valid.
- ex_rd  out  RW  held destination index.
- ex_reg_write  out  1  held write enable.
- ex_is_load  out  1  held load flag.
- hazard_stall  out  1  combinational request to ID to hold its instruction.
- bubble_cnt  out  CW  saturating count of inserted bubbles.

Behaviour:
- Reset (rst=0 at edge):
  - alu_in1=0, alu_in2=0, alu_op=ALU_ADD (0).
  - ex_valid=0, ex_rd=0, ex_reg_write=0, ex_is_load=0, bubble_cnt=0.
  - Reset wins over every other input.
- Forward match from EX2: fwd_ex = ex_valid & ex_reg_write & !ex_is_load & ex_rd!=0 & ex_rd==rs.
- Forward match from WB: fwd_wb = wb_reg_write & wb_rd!=0 & wb_rd==rs.
- Operand 1 select, in priority order: fwd_ex → ex2_result; fwd_wb → wb_data; otherwise id_rs1_val.
  - rs1==0 always yields 0, regardless of id_rs1_val or any forward source.
- Operand 2 select: id_use_imm → id_imm; otherwise the same priority chain on rs2.
- Load-use hazard, combinational:
  - hazard_stall = id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((ex_rd==id_rs1) | (!id_use_imm & ex_rd==id_rs2)).
  - The hazard is independent of id_reg_write.
- Clock-edge priority, applied after reset:
  - **stall=1:** hold every register, including bubble_cnt.
  - **flush=1 (stall=0):** load a bubble; bubble_cnt is not incremented.
  - **hazard_stall=1:** load a bubble; bubble_cnt += 1, saturating at 2^CW-1.
  - **id_valid=1:** capture the selected operands, alu_op, rd, reg_write and is_load; ex_valid=1.
  - **id_valid=0:** load a bubble; no count.
- Bubble definition:
  - ex_valid=0, ex_reg_write=0, ex_is_load=0, ex_rd=0.
  - alu_op=ALU_ADD, alu_in1=0, alu_in2=0.
- Latency:
  - ID to ALU inputs is one cycle.
  - Load-use costs exactly one bubble. The next cycle ex_valid=0 clears hazard_stall, and the load data is forwarded via the WB port.
- Simultaneous stall and flush: stall wins. Flush must be re-asserted by its source.
- hazard_stall is still driven while stall=1, but it has no effect on state.

Test Plan:
1. **Reset mid-operation.** Capture ADD r1=5, r2=7, then hold rst=0 for one edge → every output is 0, alu_op=0, ex_valid=0, bubble_cnt=0.
2. **Basic issue.** id_alu_op=SUB, rs1_val=0x0010, use_imm=1, imm=0xFFFF → next cycle alu_in1=0x0010, alu_in2=0xFFFF, alu_op=1, ex_valid=1.
3. **EX2 forwarding beats WB.** Held instruction ADD rd=3 with ex2_result=0x1234; WB writes r3=0xAAAA; ID reads rs1=3 → alu_in1=0x1234. A repeat with rs1=0 → alu_in1=0.
4. **Load-use bubble.** Held LOAD rd=2; ID issues ADD rs2=2 with use_imm=0 → hazard_stall=1, bubble captured, bubble_cnt=1. Next cycle, with wb_rd=2, wb_data=0x00C3 → hazard_stall=0 and alu_in2=0x00C3. With use_imm=1 the same ADD raises no hazard.
5. **Stall and flush priority.**
   - stall=1 with flush=1 and a valid ID instruction → all outputs unchanged.
   - Next edge with flush=1 only → ex_valid=0, bubble_cnt unchanged.
6. **Counter saturation.** With CW=8, force 260 load-use hazards → bubble_cnt=255 and it stays at 255.

Source files
------------

// File: rtl/ex1_stage.sv
// ---------------------------------------------------------------------------
// ex1_stage
// Operand-issue stage that sits between ID and the EX2 ALU. It takes a
// decoded instruction from ID and picks each operand from one of three
// places: the register file value, the EX2 result, or the WB write port.
// A load followed directly by a dependent instruction gets a one-cycle
// bubble. The ALU operands and opcode come straight from flops, so EX2
// starts its cycle with clean inputs.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   id_*                decoded instruction fields and register read data
//   stall               downstream stall, holds every register
//   flush               kills the instruction being captured
//   ex2_result          ALU result of the instruction held here
//   wb_rd/_reg_write/_data  writeback port (also carries load data)
//   alu_in1/alu_in2/alu_op  registered ALU inputs for EX2
//   ex_valid/ex_rd/ex_reg_write/ex_is_load  held instruction info
//   hazard_stall        combinational load-use hold request to ID
//   bubble_cnt          saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module ex1_stage #(
    parameter int DW = 16,
    parameter int RW = 3,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [3:0]    id_alu_op,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic [DW-1:0] id_rs1_val,
    input  logic [DW-1:0] id_rs2_val,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          id_is_load,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] ex2_result,
    input  logic [RW-1:0] wb_rd,
    input  logic          wb_reg_write,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [3:0]    alu_op,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_is_load,
    output logic          hazard_stall,
    output logic [CW-1:0] bubble_cnt
);

    localparam logic [3:0]    ALU_ADD = 4'd0;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          fwd1_ex;
    logic          fwd1_wb;
    logic          fwd2_ex;
    logic          fwd2_wb;
    logic [DW-1:0] op1_sel;
    logic [DW-1:0] op2_sel;

    // Operand selection. A held load cannot forward from EX2 because its
    // data only exists once it reaches WB, so it is excluded from the EX2
    // match. EX2 is younger than WB and therefore wins when both match.
    // Register r0 always reads as zero, whatever any forward source says.
    always_comb begin
        fwd1_ex = ex_valid && ex_reg_write && !ex_is_load &&
                  (ex_rd != '0) && (ex_rd == id_rs1);
        fwd1_wb = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
        fwd2_ex = ex_valid && ex_reg_write && !ex_is_load &&
                  (ex_rd != '0) && (ex_rd == id_rs2);
        fwd2_wb = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);

        op1_sel = id_rs1_val;
        if (id_rs1 == '0) begin
            op1_sel = '0;
        end else if (fwd1_ex) begin
            op1_sel = ex2_result;
        end else if (fwd1_wb) begin
            op1_sel = wb_data;
        end

        op2_sel = id_rs2_val;
        if (id_use_imm) begin
            op2_sel = id_imm;
        end else if (id_rs2 == '0) begin
            op2_sel = '0;
        end else if (fwd2_ex) begin
            op2_sel = ex2_result;
        end else if (fwd2_wb) begin
            op2_sel = wb_data;
        end
    end

    // Load-use detection: the held load's data is not available until the
    // next cycle (via WB), so a dependent ID instruction must wait one
    // cycle. rs2 only matters when the immediate is not selected.
    assign hazard_stall = id_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                          ((ex_rd == id_rs1) || (!id_use_imm && (ex_rd == id_rs2)));

    // Pipeline register. Stall freezes everything. Otherwise a bubble is
    // loaded on flush, on a load-use hazard or when ID has nothing valid;
    // only hazard bubbles are counted, and the count saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_in1      <= '0;
            alu_in2      <= '0;
            alu_op       <= ALU_ADD;
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
            bubble_cnt   <= '0;
        end else if (!stall) begin
            if (flush || hazard_stall || !id_valid) begin
                alu_in1      <= '0;
                alu_in2      <= '0;
                alu_op       <= ALU_ADD;
                ex_valid     <= 1'b0;
                ex_rd        <= '0;
                ex_reg_write <= 1'b0;
                ex_is_load   <= 1'b0;
                if (!flush && hazard_stall && (bubble_cnt != CNT_MAX)) begin
                    bubble_cnt <= bubble_cnt + CW'(1);
                end
            end else begin
                alu_in1      <= op1_sel;
                alu_in2      <= op2_sel;
                alu_op       <= id_alu_op;
                ex_valid     <= 1'b1;
                ex_rd        <= id_rd;
                ex_reg_write <= id_reg_write;
                ex_is_load   <= id_is_load;
            end
        end
    end

endmodule
